uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin arbiter and sequencer that shares a single `uart_master` transmitter among `NUM_REQ` byte producers. It accepts one byte per grant, drives the transmitter's `en_tx`/`data` inputs, and holds them stable until the transmitter's `u_tx_done`. It then enforces an idle gap before the next grant. It sits between the requesting logic and `uart_master`, on the same `clk` as the `uart_intf` datapath.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 8: byte width; matches transmitter `data`.
- `GAP_CYC`, 2: idle cycles between transfers, ≥1.
- `TIMEOUT_CYC`, 20000: watchdog limit in cycles. Used only with `UART_ARB_TIMEOUT_EN`.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset; synchronous, active-low.
- `req` in NUM_REQ: per-requester request level.
- `req_data` in NUM_REQ*DATA_W: requester i's byte at bits [i*DATA_W +: DATA_W].
- `gnt` out NUM_REQ: one-hot, 1-cycle pulse; byte from that requester accepted.
- `done` out NUM_REQ: one-hot, 1-cycle pulse; that requester's byte fully transmitted.
- `err` out 1: 1-cycle pulse; transfer aborted by watchdog.
- `busy` out 1: high in BUSY and GAP.
- `en_tx` out 1: transmitter enable, to `uart_master.en_tx`.
- `tx_data` out DATA_W: to `uart_master.data`.
- `tx_done` in 1: from `uart_master.u_tx_done`; 1-cycle pulse at end of stop bit.

## Operation
- Reset (`rst_n`=0 at a rising edge):
  - state IDLE, round-robin pointer `ptr`=0, gap and watchdog counters 0.
  - Outputs: `gnt`=0, `done`=0, `err`=0, `busy`=0, `en_tx`=0, `tx_data`=0.
  - Reset mid-transfer drops `en_tx` on that edge. No `done` is issued for the aborted byte.
- States: IDLE, BUSY, GAP.
- IDLE:
  - If any `req` bit is set, select the first set bit searching from `ptr` upward with wrap (ptr, ptr+1, …, NUM_REQ-1, 0, …).
  - At that edge: `gnt[i]`=1, `owner`=i, `tx_data`=`req_data[i]`, `en_tx`=1, `ptr`=(i+1) mod NUM_REQ. Go to BUSY.
  - With no request, stay in IDLE; all outputs remain 0.
- BUSY:
  - `en_tx`=1; `tx_data` held constant; `req` and `req_data` are ignored.
  - On an edge with `tx_done`=1: `en_tx`=0, `done[owner]`=1, gap counter=GAP_CYC-1. Go to GAP.
- GAP:
  - `en_tx`=0. Decrement the gap counter each cycle.
  - At 0, go to IDLE. No arbitration occurs in GAP.
- Requester contract:
  - Hold `req[i]` and `req_data[i]` stable until `gnt[i]`.
  - A `req[i]` still high in the first IDLE cycle after GAP is treated as a new request.
- `tx_done` while in IDLE or GAP is ignored.
- `tx_data` retains its last value outside BUSY.

## Timing
- Request seen at IDLE edge k: `gnt`, `en_tx`=1, and `tx_data` are valid from k+1. Grant latency is 1 cycle.
- `tx_done` sampled at edge m: `done` pulses and `en_tx`=0 in cycle m+1.
- GAP occupies cycles m+1 .. m+GAP_CYC. IDLE is reached at m+GAP_CYC+1, and the earliest next `gnt` is at m+GAP_CYC+2.
- `en_tx` is low for at least GAP_CYC+1 cycles between consecutive transfers.
- `gnt` and `done` never coincide for the same requester in the same cycle.
- `gnt` and `done` are never multi-hot.
- All outputs are registered.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - The watchdog counter clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT_CYC without `tx_done`: `en_tx`=0, `err`=1 for 1 cycle, no `done`. Go to GAP.
  - `ptr` is already advanced, so the stalled requester loses its turn.
  - If `tx_done` and the timeout coincide, `tx_done` wins.
- Undefined:
  - No counter is built; `err` is tied to 0.
  - BUSY waits for `tx_done` indefinitely.

## Test plan
- Single requester: reset, then `req`=4'b0010 with `req_data[1]`=8'hA5.
  - Required: `gnt`=4'b0010 one cycle later, `en_tx`=1, `tx_data`=8'hA5 held until `tx_done`.
  - Required: `done`=4'b0010 the cycle after `tx_done`; `serial_line` is decoded as 8'hA5 by `uart_slave`.
- Fairness: all four `req` held high with bytes 8'h10..8'h13.
  - Required: grant order 0,1,2,3,0.
  - Required: each gap has at least GAP_CYC+1 cycles of `en_tx`=0; `rx_done` data sequence 10,11,12,13.
- Pointer wrap: grant to requester 3, then `req`=4'b1001.
  - Required: next grant goes to 0, not 3.
- Reset mid-transfer: assert `rst_n`=0 for 1 cycle during BUSY.
  - Required: `en_tx`=0, `busy`=0, and `gnt`/`done`/`err`=0 next cycle; `ptr`=0; no `done` for the aborted byte.
- Request during BUSY/GAP: raise `req[2]` mid-transfer.
  - Required: no `gnt` until IDLE.
  - Required: `gnt[2]` exactly at m+GAP_CYC+2 relative to the `tx_done` edge m.
- Watchdog, with `UART_ARB_TIMEOUT_EN` and TIMEOUT_CYC=50: stub `tx_done` to 0.
  - Required: `err` pulse 50 cycles after the grant, `en_tx`=0, no `done`, next requester served after GAP.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that shares one UART transmitter
// among NUM_REQ byte producers. One byte is accepted per grant and held on
// en_tx/tx_data until the transmitter reports tx_done. After that, a fixed
// idle gap runs before the next arbitration.
// Optional feature: define UART_ARB_TIMEOUT_EN to add a BUSY watchdog that
// aborts a stalled transfer after TIMEOUT_CYC cycles and pulses err.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int GAP_CYC     = 2,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic                      err,
    output logic                      busy,
    output logic                      en_tx,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_done
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GW = $clog2(GAP_CYC + 1);

    // Reject configurations the sequencing cannot honour.
    if (NUM_REQ < 2 || NUM_REQ > 8 || GAP_CYC < 1 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("uart_tx_arbiter: illegal parameter set");
    end

    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [PW-1:0]       owner_q, owner_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic                busy_q, busy_d;
    logic                en_tx_q, en_tx_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;

    logic [PW-1:0]       sel;
    logic                hit;
    logic                timeout;

    // Round-robin pick: first set req bit at or above ptr, wrapping to 0.
    always_comb begin
        int idx;
        sel = '0;
        hit = 1'b0;
        idx = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = (int'(ptr_q) + off) % NUM_REQ;
            if (!hit && req[idx]) begin
                hit = 1'b1;
                sel = PW'(idx);
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    logic [WW-1:0] wd_q;
    logic          err_q;

    // tx_done has priority over an expiring watchdog in the same cycle.
    assign timeout = (state_q == BUSY) && !tx_done && (wd_q == WW'(TIMEOUT_CYC - 1));

    // Watchdog counts BUSY cycles; it sits at 0 outside BUSY so entry starts clean.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= (state_q == BUSY && !timeout && !tx_done) ? wd_q + WW'(1) : '0;
            err_q <= timeout;
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            gap_q     <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            busy_q    <= 1'b0;
            en_tx_q   <= 1'b0;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            gap_q     <= gap_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            en_tx_q   <= en_tx_d;
            tx_data_q <= tx_data_d;
        end
    end

    // Next-state: IDLE arbitrates, BUSY waits for the transmitter, GAP counts down.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hit) state_d = BUSY;
            BUSY:    if (tx_done || timeout) state_d = GAP;
            GAP:     if (gap_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and bookkeeping registers.
    always_comb begin
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        gap_d     = gap_q;
        gnt_d     = '0;
        done_d    = '0;
        en_tx_d   = 1'b0;
        tx_data_d = tx_data_q;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    gnt_d[sel] = 1'b1;
                    owner_d    = sel;
                    tx_data_d  = req_data[int'(sel)*DATA_W +: DATA_W];
                    en_tx_d    = 1'b1;
                    ptr_d      = PW'((int'(sel) + 1) % NUM_REQ);
                end
            end
            BUSY: begin
                en_tx_d = 1'b1;
                if (tx_done) begin
                    en_tx_d         = 1'b0;
                    done_d[owner_q] = 1'b1;
                    gap_d           = GW'(GAP_CYC - 1);
                end else if (timeout) begin
                    en_tx_d = 1'b0;
                    gap_d   = GW'(GAP_CYC - 1);
                end
            end
            GAP: begin
                if (gap_q != '0) gap_d = gap_q - GW'(1);
            end
            default: ;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign busy    = busy_q;
    assign en_tx   = en_tx_q;
    assign tx_data = tx_data_q;

endmodule
